// File: rtl/lc3_execute.sv
// LC-3 execute stage: ALU, address adder and the execute/memory pipeline register.
// Register-file read addresses are driven combinationally from the incoming IR.
module lc3_execute #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [5:0]        E_Control,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] M_Data,
  output logic [2:0]        dr,
  output logic [2:0]        NZP,
  output logic [15:0]       IR_exec,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0] opcode;
  logic [1:0] alu_ctl;
  logic [1:0] pcsel1;
  logic       pcsel2;
  logic       op2sel;

  assign opcode  = IR[15:12];
  assign alu_ctl = E_Control[5:4];
  assign pcsel1  = E_Control[3:2];
  assign pcsel2  = E_Control[1];
  assign op2sel  = E_Control[0];

  // Stores read their data register through port 2 from the DR field.
  always_comb begin
    sr1 = IR[8:6];
    sr2 = IR[2:0];
    if (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI)
      sr2 = IR[11:9];
  end

  logic [DATA_W-1:0] imm5_sext;
  logic [DATA_W-1:0] off6_sext;
  logic [DATA_W-1:0] off9_sext;
  logic [DATA_W-1:0] off11_sext;

  assign imm5_sext  = {{(DATA_W-5){IR[4]}},   IR[4:0]};
  assign off6_sext  = {{(DATA_W-6){IR[5]}},   IR[5:0]};
  assign off9_sext  = {{(DATA_W-9){IR[8]}},   IR[8:0]};
  assign off11_sext = {{(DATA_W-11){IR[10]}}, IR[10:0]};

  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    op2 = op2sel ? VSR2 : imm5_sext;
    alu_res = '0;
    case (alu_ctl)
      2'b00:   alu_res = VSR1 + op2;
      2'b01:   alu_res = VSR1 & op2;
      2'b10:   alu_res = ~VSR1;
      default: alu_res = '0;
    endcase
  end

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] addr;

  always_comb begin
    add_a = pcsel2 ? npc_in : VSR1;
    add_b = '0;
    case (pcsel1)
      2'b00:   add_b = off11_sext;
      2'b01:   add_b = off9_sext;
      2'b10:   add_b = off6_sext;
      default: add_b = '0;
    endcase
    addr = add_a + add_b;
  end

  logic [DATA_W-1:0] aluout_d, aluout_q;
  logic [DATA_W-1:0] pcout_d, pcout_q;
  logic [DATA_W-1:0] m_data_d, m_data_q;
  logic [2:0]        dr_d, dr_q;
  logic [2:0]        nzp_d, nzp_q;
  logic [15:0]       ir_exec_d, ir_exec_q;
  logic [1:0]        w_control_d, w_control_q;
  logic              mem_control_d, mem_control_q;

  // Next-state values; when the stage is stalled every register recirculates.
  always_comb begin
    aluout_d      = aluout_q;
    pcout_d       = pcout_q;
    m_data_d      = m_data_q;
    dr_d          = dr_q;
    nzp_d         = nzp_q;
    ir_exec_d     = ir_exec_q;
    w_control_d   = w_control_q;
    mem_control_d = mem_control_q;
    if (enable_execute) begin
      pcout_d       = addr;
      m_data_d      = VSR2;
      ir_exec_d     = IR;
      w_control_d   = W_Control_in;
      mem_control_d = Mem_Control_in;
      aluout_d      = addr;
      dr_d          = 3'b000;
      nzp_d         = 3'b000;
      case (opcode)
        OP_ADD, OP_AND, OP_NOT: begin
          aluout_d = alu_res;
          dr_d     = IR[11:9];
        end
        OP_LD, OP_LDR, OP_LDI, OP_LEA: dr_d = IR[11:9];
        OP_BR:  nzp_d = IR[11:9];
        OP_JMP: nzp_d = 3'b111;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      m_data_q      <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      ir_exec_q     <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
    end else begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      ir_exec_q     <= ir_exec_d;
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = m_data_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign IR_exec         = ir_exec_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed-vector bench for lc3_execute with hand-computed expectations.
module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  int n_assert = 0;
  int n_fail   = 0;

  lc3_execute #(.DATA_W(16)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .E_Control(E_Control), .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
    .IR(IR), .npc_in(npc_in), .VSR1(VSR1), .VSR2(VSR2),
    .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .M_Data(M_Data),
    .dr(dr), .NZP(NZP), .IR_exec(IR_exec),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ir, input logic [5:0] ectl,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [15:0] npc, input logic [1:0] w, input logic m);
    IR = ir; E_Control = ectl; VSR1 = v1; VSR2 = v2;
    npc_in = npc; W_Control_in = w; Mem_Control_in = m;
  endtask

  // Inputs change after the falling edge; registered outputs sampled 1 after the rising edge.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable_execute = 1'b0;
    drive(16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
    #12;
    check_val("rst_aluout", aluout, 16'h0000);
    check_val("rst_pcout", pcout, 16'h0000);
    check_val("rst_ir_exec", IR_exec, 16'h0000);
    check_val("rst_dr_nzp", {10'd0, dr, NZP}, 16'h0000);
    @(negedge clock);
    reset = 1'b0; enable_execute = 1'b1;

    // ADD register form
    drive(16'h1642, 6'b000001, 16'd5, 16'd7, 16'h3000, 2'b10, 1'b1);
    #1;
    check_val("add_sr1", {13'd0, sr1}, 16'd1);
    check_val("add_sr2", {13'd0, sr2}, 16'd2);
    step();
    check_val("add_aluout", aluout, 16'd12);
    check_val("add_dr", {13'd0, dr}, 16'd3);
    check_val("add_nzp", {13'd0, NZP}, 16'd0);
    check_val("add_ir_exec", IR_exec, 16'h1642);
    check_val("add_wctl", {14'd0, W_Control_out}, 16'd2);
    check_val("add_mctl", {15'd0, Mem_Control_out}, 16'd1);

    // AND immediate with imm5 = -1
    @(negedge clock);
    drive(16'h547F, 6'b010000, 16'h00F0, 16'h1234, 16'h3001, 2'b01, 1'b0);
    step();
    check_val("and_aluout", aluout, 16'h00F0);
    check_val("and_dr", {13'd0, dr}, 16'd2);

    // NOT
    @(negedge clock);
    drive(16'h927F, 6'b100000, 16'h00FF, 16'h0000, 16'h3002, 2'b01, 1'b0);
    step();
    check_val("not_aluout", aluout, 16'hFF00);
    check_val("not_dr", {13'd0, dr}, 16'd1);

    // BR nzp=101 with offset -2
    @(negedge clock);
    drive(16'h0BFE, 6'b000110, 16'h1111, 16'h2222, 16'h3005, 2'b00, 1'b0);
    step();
    check_val("br_pcout", pcout, 16'h3003);
    check_val("br_aluout", aluout, 16'h3003);
    check_val("br_nzp", {13'd0, NZP}, 16'h0005);
    check_val("br_dr", {13'd0, dr}, 16'd0);

    // ADD wraparound FFFF + imm 1
    @(negedge clock);
    drive(16'h1021, 6'b000000, 16'hFFFF, 16'h0000, 16'h3006, 2'b10, 1'b0);
    step();
    check_val("wrap_aluout", aluout, 16'h0000);
    check_val("wrap_dr", {13'd0, dr}, 16'd0);

    // STR: sr2 from DR field, base+off6
    @(negedge clock);
    drive(16'h7A43, 6'b001000, 16'h4000, 16'hBEEF, 16'h3007, 2'b11, 1'b1);
    #1;
    check_val("str_sr1", {13'd0, sr1}, 16'd1);
    check_val("str_sr2", {13'd0, sr2}, 16'd5);
    step();
    check_val("str_pcout", pcout, 16'h4003);
    check_val("str_aluout", aluout, 16'h4003);
    check_val("str_mdata", M_Data, 16'hBEEF);
    check_val("str_dr", {13'd0, dr}, 16'd0);
    check_val("str_wctl", {14'd0, W_Control_out}, 16'd3);
    check_val("str_mctl", {15'd0, Mem_Control_out}, 16'd1);

    // JMP through base register
    @(negedge clock);
    drive(16'hC1C0, 6'b001100, 16'h5A5A, 16'h0000, 16'h3008, 2'b00, 1'b0);
    step();
    check_val("jmp_nzp", {13'd0, NZP}, 16'h0007);
    check_val("jmp_pcout", pcout, 16'h5A5A);
    check_val("jmp_dr", {13'd0, dr}, 16'd0);

    // LEA with off9 = -1
    @(negedge clock);
    drive(16'hE5FF, 6'b000110, 16'h0000, 16'h0000, 16'h3000, 2'b10, 1'b0);
    step();
    check_val("lea_aluout", aluout, 16'h2FFF);
    check_val("lea_dr", {13'd0, dr}, 16'd2);

    // Unused opcode 1101: address only
    @(negedge clock);
    drive(16'hD123, 6'b000000, 16'h0100, 16'h0000, 16'h3000, 2'b00, 1'b0);
    step();
    check_val("unused_aluout", aluout, 16'h0223);
    check_val("unused_dr_nzp", {10'd0, dr, NZP}, 16'h0000);

    // Hold: load ADD 12, then stall for 3 cycles with changing inputs
    @(negedge clock);
    drive(16'h1642, 6'b000001, 16'd5, 16'd7, 16'h3000, 2'b10, 1'b1);
    step();
    check_val("hold_load", aluout, 16'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      enable_execute = 1'b0;
      drive(16'h7A43 + 16'(i), 6'b001000, 16'h4000 + 16'(i), 16'hBEEF, 16'h3100, 2'b01, 1'b0);
      #1;
      check_val("hold_sr2", {13'd0, sr2}, 16'd5);
      check_val("hold_sr1", {13'd0, sr1}, 16'd1);
      step();
      check_val("hold_aluout", aluout, 16'd12);
      check_val("hold_dr", {13'd0, dr}, 16'd3);
      check_val("hold_ir_exec", IR_exec, 16'h1642);
      check_val("hold_mdata", M_Data, 16'd7);
      check_val("hold_wm", {13'd0, W_Control_out, Mem_Control_out}, 16'h0005);
    end

    // Asynchronous reset between edges
    @(negedge clock);
    enable_execute = 1'b1;
    reset = 1'b1;
    #1;
    check_val("arst_aluout", aluout, 16'h0000);
    check_val("arst_ir_exec", IR_exec, 16'h0000);
    check_val("arst_mdata", M_Data, 16'h0000);
    check_val("arst_ctl", {10'd0, dr, NZP}, 16'h0000);
    check_val("arst_wm", {13'd0, W_Control_out, Mem_Control_out}, 16'h0000);
    step();
    check_val("arst_dominates", aluout, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    drive(16'h547F, 6'b010000, 16'h0F0F, 16'h0000, 16'h3000, 2'b01, 1'b1);
    step();
    check_val("post_rst_aluout", aluout, 16'h0F0F);
    check_val("post_rst_ir_exec", IR_exec, 16'h547F);
    check_val("post_rst_dr", {13'd0, dr}, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
